// File: rtl/ext_sram_word_bridge.sv
// Splits one CPU byte/half/word request into 16-bit external-SRAM stage transactions
// (one per written byte, one per read halfword) and returns a single packed response.
module ext_sram_word_bridge #(
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        sram_valid,
   output logic        sram_rw,
   output logic [31:0] sram_addr,
   output logic [15:0] sram_dtw,
   input  logic [15:0] sram_dtr,
   input  logic        sram_done
);

   // state | meaning
   // IDLE  | req_ready high, waiting for a request
   // ISSUE | sram_valid high with stable rw/addr/dtw, waiting for sram_done
   // GAP   | sram_valid low for GAP_CYCLES, next op address/data already loaded
   // RESP  | one-cycle resp_valid pulse, back to IDLE next cycle

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} state_t;

   localparam int unsigned   GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   state_t        state;
   logic          lat_rw;
   logic [1:0]    lat_size;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [2:0]    op_cnt;
   logic [2:0]    op_total;
   logic [2:0]    op_next;
   logic [GW-1:0] gap_cnt;
   logic [15:0]   rdata_lo;

   assign op_next = op_cnt + 3'd1;

   function automatic logic [2:0] ops_for(input logic rw, input logic [1:0] size);
      logic [2:0] n;
      n = 3'd1;
      if (rw)
         n = (size == 2'b10) ? 3'd4 : (size == 2'b01) ? 3'd2 : 3'd1;
      else if (size == 2'b10)
         n = 3'd2;
      return n;
   endfunction

   // Writes walk byte by byte; reads walk halfword by halfword. Byte reads fetch the
   // containing halfword and select the lane when the response is packed.
   function automatic logic [31:0] op_addr(input logic rw, input logic [1:0] size,
                                           input logic [31:0] addr, input logic [2:0] k);
      logic [31:0] a;
      if (rw)
         a = addr + {29'd0, k};
      else if (size == 2'b00)
         a = {addr[31:1], 1'b0};
      else
         a = addr + {28'd0, k, 1'b0};
      return a;
   endfunction

   function automatic logic [15:0] op_dtw(input logic rw, input logic [31:0] wdata,
                                          input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = wdata[7:0];
         2'd1:    b = wdata[15:8];
         2'd2:    b = wdata[23:16];
         default: b = wdata[31:24];
      endcase
      return rw ? {b, b} : 16'd0;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a_lo);
      return (size == 2'b11) || (size == 2'b01 && a_lo[0]) ||
             (size == 2'b10 && a_lo != 2'b00);
   endfunction

   function automatic logic [31:0] read_result(input logic [1:0] size, input logic a0,
                                               input logic [15:0] lo, input logic [15:0] dtr);
      logic [31:0] r;
      case (size)
         2'b00:   r = {24'd0, (a0 ? dtr[15:8] : dtr[7:0])};
         2'b01:   r = {16'd0, dtr};
         default: r = {dtr, lo};
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         sram_valid <= 1'b0;
         sram_rw    <= 1'b0;
         sram_addr  <= 32'd0;
         sram_dtw   <= 16'd0;
         lat_rw     <= 1'b0;
         lat_size   <= 2'b00;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         op_cnt     <= 3'd0;
         op_total   <= 3'd0;
         gap_cnt    <= '0;
         rdata_lo   <= 16'd0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  lat_rw    <= req_rw;
                  lat_size  <= req_size;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  op_cnt    <= 3'd0;
                  req_ready <= 1'b0;
                  if (misaligned(req_size, req_addr[1:0])) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state      <= ISSUE;
                     op_total   <= ops_for(req_rw, req_size);
                     sram_valid <= 1'b1;
                     sram_rw    <= req_rw;
                     sram_addr  <= op_addr(req_rw, req_size, req_addr, 3'd0);
                     sram_dtw   <= op_dtw(req_rw, req_wdata, 2'd0);
                  end
               end
            end
            ISSUE: begin
               if (sram_done) begin
                  sram_valid <= 1'b0;
                  op_cnt     <= op_next;
                  if (op_cnt == 3'd0)
                     rdata_lo <= sram_dtr;
                  if (op_next == op_total) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= lat_rw ? 32'd0 :
                                   read_result(lat_size, lat_addr[0], rdata_lo, sram_dtr);
                  end else begin
                     state     <= GAP;
                     gap_cnt   <= GAP_LOAD;
                     sram_addr <= op_addr(lat_rw, lat_size, lat_addr, op_next);
                     sram_dtw  <= op_dtw(lat_rw, lat_wdata, op_next[1:0]);
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state      <= ISSUE;
                  sram_valid <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_sram_word_bridge.sv
// Bench for ext_sram_word_bridge: an SRAM-stage responder with random latency and stray
// done pulses, plus a byte-addressed reference memory that predicts every response.
module tb_ext_sram_word_bridge;
   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rw = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        sram_valid;
   logic        sram_rw;
   logic [31:0] sram_addr;
   logic [15:0] sram_dtw;
   logic [15:0] sram_dtr = 16'd0;
   logic        sram_done = 1'b0;

   ext_sram_word_bridge #(.GAP_CYCLES(GAP)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .sram_valid(sram_valid), .sram_rw(sram_rw), .sram_addr(sram_addr),
      .sram_dtw(sram_dtw), .sram_dtr(sram_dtr), .sram_done(sram_done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int sum_lat = 0;

   logic [7:0]  sram_mem [logic [31:0]];
   logic [7:0]  ref_mem  [logic [31:0]];
   logic [31:0] op_addr_q [$];
   logic        op_rw_q   [$];
   logic [15:0] op_dtw_q  [$];
   logic [31:0] e_addr    [$];
   logic [15:0] e_dtw     [$];

   function automatic logic [31:0] b32(input logic x);
      return {31'd0, x};
   endfunction

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      return sram_mem.exists(a) ? sram_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // SRAM stage: done after 1..3 valid cycles; stray done pulses while valid is low.
   initial begin : responder
      int cnt;
      int lat;
      bit stray;
      bit jc;
      logic [31:0] a_rec;
      logic [31:0] a0;
      logic        rw_rec;
      logic [15:0] dtw_rec;
      cnt = 0; lat = 1; stray = 0;
      a_rec = 32'd0; rw_rec = 1'b0; dtw_rec = 16'd0;
      forever begin
         @(negedge clk);
         jc = 0;
         if (sram_done) begin
            sram_done = 1'b0;
            jc = 1;
            if (!stray) chk("valid_after_done", b32(sram_valid), 32'd0);
            stray = 0;
         end
         if (sram_valid) begin
            if (cnt == 0) begin
               a_rec = sram_addr; rw_rec = sram_rw; dtw_rec = sram_dtw;
               op_addr_q.push_back(a_rec);
               op_rw_q.push_back(rw_rec);
               op_dtw_q.push_back(dtw_rec);
               lat = int'($urandom_range(1, 3));
            end else begin
               chk("op_addr_stable", sram_addr, a_rec);
               chk("op_rw_stable", b32(sram_rw), b32(rw_rec));
               chk("op_dtw_stable", {16'd0, sram_dtw}, {16'd0, dtw_rec});
            end
            cnt++;
            if (cnt == lat) begin
               if (rw_rec)
                  sram_mem[a_rec] = a_rec[0] ? dtw_rec[15:8] : dtw_rec[7:0];
               else begin
                  a0 = {a_rec[31:1], 1'b0};
                  sram_dtr = {mem_rd(a0 + 32'd1), mem_rd(a0)};
               end
               sram_done = 1'b1;
               stray = 0;
               sum_lat += lat;
               cnt = 0;
            end
         end else begin
            cnt = 0;
            if (!jc && $urandom_range(0, 7) == 0) begin
               sram_done = 1'b1;
               stray = 1;
               sram_dtr = 16'($urandom);
            end
         end
      end
   end

   function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
   endfunction

   // Expected op list: one op per written byte, one per read halfword.
   task automatic build_exp(input logic rw, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
      int nb;
      nb = 1 << sz;
      if (is_err(sz, a)) return;
      if (rw) begin
         for (int i = 0; i < nb; i++) begin
            e_addr.push_back(a + 32'(i));
            e_dtw.push_back({2{8'(wd >> (8 * i))}});
         end
      end else if (sz == 2'b00) begin
         e_addr.push_back({a[31:1], 1'b0});
         e_dtw.push_back(16'd0);
      end else begin
         for (int i = 0; i < nb / 2; i++) begin
            e_addr.push_back(a + 32'(2 * i));
            e_dtw.push_back(16'd0);
         end
      end
   endtask

   function automatic logic [31:0] ref_rdata(input logic [1:0] sz, input logic [31:0] a);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < (1 << sz); i++)
         r = r | (32'(ref_rd(a + 32'(i))) << (8 * i));
      return r;
   endfunction

   task automatic ref_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      for (int i = 0; i < (1 << sz); i++)
         ref_mem[a + 32'(i)] = 8'(wd >> (8 * i));
   endtask

   task automatic clear_ops();
      op_addr_q.delete(); op_rw_q.delete(); op_dtw_q.delete();
   endtask

   task automatic wait_resp(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!resp_valid && k < 400);
   endtask

   task automatic check_ops(input string tag, input logic rw);
      int n;
      chk({tag, "_nops"}, 32'(op_addr_q.size()), 32'(e_addr.size()));
      n = (op_addr_q.size() < e_addr.size()) ? op_addr_q.size() : e_addr.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_op%0d_addr", tag, i), op_addr_q[i], e_addr[i]);
         chk($sformatf("%s_op%0d_rw", tag, i), b32(op_rw_q[i]), b32(rw));
         if (rw) chk($sformatf("%s_op%0d_dtw", tag, i), {16'd0, op_dtw_q[i]}, {16'd0, e_dtw[i]});
      end
   endtask

   task automatic run_req(input string tag, input logic rw, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
      logic [31:0] er;
      bit ee;
      int k;
      int exp_k;
      ee = is_err(sz, a);
      e_addr.delete(); e_dtw.delete();
      build_exp(rw, sz, a, wd);
      er = (rw || ee) ? 32'd0 : ref_rdata(sz, a);
      clear_ops();
      sum_lat = 0;
      @(negedge clk);
      req_valid = 1'b1; req_rw = rw; req_size = sz; req_addr = a; req_wdata = wd;
      k = 0;
      while (!req_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_ready"}, b32(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk({tag, "_ready_low"}, b32(req_ready), 32'd0);
      wait_resp(k);
      exp_k = ee ? 1 : sum_lat + (e_addr.size() - 1) * GAP + 1;
      chk({tag, "_resp_valid"}, b32(resp_valid), 32'd1);
      chk({tag, "_resp_err"}, b32(resp_err), b32(ee));
      chk({tag, "_rdata"}, resp_rdata, er);
      chk({tag, "_latency"}, 32'(k), 32'(exp_k));
      rd = resp_rdata;
      check_ops(tag, rw);
      @(negedge clk);
      chk({tag, "_ready_back"}, b32(req_ready), 32'd1);
      chk({tag, "_resp_pulse"}, b32(resp_valid), 32'd0);
      if (rw && !ee) ref_write(sz, a, wd);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] rd;
      logic [15:0] ww_dtw [4];
      int k;
      bit saw;
      logic rw;
      logic [1:0] sz;
      logic [31:0] a;
      ww_dtw = '{16'hD4D4, 16'hC3C3, 16'hB2B2, 16'hA1A1};

      repeat (3) @(negedge clk);
      chk("rst_ready", b32(req_ready), 32'd1);
      chk("rst_resp_valid", b32(resp_valid), 32'd0);
      chk("rst_sram_valid", b32(sram_valid), 32'd0);
      chk("rst_sram_addr", sram_addr, 32'd0);
      rstn = 1'b1;

      // Reset in the middle of a word write.
      clear_ops();
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 32'h104; req_wdata = 32'hA1B2C3D4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      k = 0;
      while (!sram_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("midrst_valid_seen", b32(sram_valid), 32'd1);
      #2 rstn = 1'b0;
      #1 chk("midrst_valid_async", b32(sram_valid), 32'd0);
      saw = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) saw = 1;
      end
      rstn = 1'b1;
      #1;
      chk("postrst_ready", b32(req_ready), 32'd1);
      chk("postrst_outs", {29'd0, resp_valid, resp_err, sram_valid}, 32'd0);
      chk("postrst_rdata", resp_rdata, 32'd0);
      chk("postrst_sram", sram_addr | {16'd0, sram_dtw} | b32(sram_rw), 32'd0);
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) saw = 1;
      end
      chk("midrst_no_resp", b32(saw), 32'd0);
      for (int i = 0; i < 4; i++)
         if (sram_mem.exists(32'h104 + 32'(i))) ref_mem[32'h104 + 32'(i)] = sram_mem[32'h104 + 32'(i)];

      run_req("word_wr", 1'b1, 2'b10, 32'h104, 32'hA1B2C3D4, rd);
      if (op_dtw_q.size() == 4)
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("word_wr_const_addr%0d", i), op_addr_q[i], 32'h104 + 32'(i));
            chk($sformatf("word_wr_const_dtw%0d", i), {16'd0, op_dtw_q[i]}, {16'd0, ww_dtw[i]});
         end

      sram_mem[32'h200] = 8'h78; sram_mem[32'h201] = 8'h56; sram_mem[32'h202] = 8'h34; sram_mem[32'h203] = 8'h12;
      ref_mem[32'h200]  = 8'h78; ref_mem[32'h201]  = 8'h56; ref_mem[32'h202]  = 8'h34; ref_mem[32'h203]  = 8'h12;
      run_req("word_rd", 1'b0, 2'b10, 32'h200, 32'd0, rd);
      chk("word_rd_const", rd, 32'h12345678);

      sram_mem[32'h300] = 8'hEF; sram_mem[32'h301] = 8'hBE;
      ref_mem[32'h300]  = 8'hEF; ref_mem[32'h301]  = 8'hBE;
      run_req("byte_rd", 1'b0, 2'b00, 32'h301, 32'd0, rd);
      chk("byte_rd_const", rd, 32'h000000BE);

      run_req("mis_half", 1'b0, 2'b01, 32'h11, 32'd0, rd);
      run_req("mis_word", 1'b1, 2'b10, 32'h22, 32'hDEADBEEF, rd);
      run_req("mis_size", 1'b0, 2'b11, 32'h40, 32'd0, rd);

      run_req("wrap_wr", 1'b1, 2'b10, 32'hFFFFFFFC, 32'h11223344, rd);
      run_req("wrap_rd", 1'b0, 2'b10, 32'hFFFFFFFC, 32'd0, rd);
      chk("wrap_rd_const", rd, 32'h11223344);

      // Back-to-back half writes with req_valid held.
      e_addr.delete(); e_dtw.delete();
      build_exp(1'b1, 2'b01, 32'h40, 32'h0102);
      build_exp(1'b1, 2'b01, 32'h42, 32'h0304);
      clear_ops();
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b01; req_addr = 32'h40; req_wdata = 32'h0102;
      @(posedge clk);
      #1 req_addr = 32'h42; req_wdata = 32'h0304;
      wait_resp(k);
      chk("b2b_first_resp", {30'd0, resp_valid, resp_err}, 32'd2);
      @(negedge clk);
      chk("b2b_ready_idle", b32(req_ready), 32'd1);
      @(posedge clk);
      #1 chk("b2b_second_accept", b32(req_ready), 32'd0);
      req_valid = 1'b0;
      wait_resp(k);
      chk("b2b_second_resp", {30'd0, resp_valid, resp_err}, 32'd2);
      check_ops("b2b", 1'b1);
      if (op_addr_q.size() == 4)
         for (int i = 0; i < 4; i++)
            chk($sformatf("b2b_const_addr%0d", i), op_addr_q[i], 32'h40 + 32'(i));
      ref_write(2'b01, 32'h40, 32'h0102);
      ref_write(2'b01, 32'h42, 32'h0304);
      @(negedge clk);

      for (int n = 0; n < 40; n++) begin
         rw = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
         else a = 32'h1000 + 32'($urandom_range(0, 63));
         if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         run_req($sformatf("rnd%0d", n), rw, sz, a, $urandom, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
